// File: rtl/comp_seq_2bit.sv
// comp_seq_2bit: sequential WIDTH-bit magnitude comparator controller.
// Streams two latched operands MSB-first, one 2-bit slice per cycle, into an
// external 2-bit comparator and folds its l/e/g answers into a word-level
// result. Stops on the first unequal slice and reports with start/done.
// WIDTH must be even and at least 2.
module comp_seq_2bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             cmp_l,
  input  logic             cmp_e,
  input  logic             cmp_g,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g,
  output logic             err
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Operands are held as arrays of 2-bit slices so the slice index selects
  // directly, without any shift arithmetic.
  typedef logic [NSLICE-1:0][1:0] word_t;

  state_t          state_q, state_d;
  word_t           a_q, a_d;
  word_t           b_q, b_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            done_d;
  logic            l_d, e_d, g_d, err_d;
  logic            cmp_onehot;

  // Slices decode from registers only, so they hold steady in IDLE.
  assign slice_a    = a_q[idx_q];
  assign slice_b    = b_q[idx_q];
  assign busy       = (state_q == RUN);
  assign cmp_onehot = $onehot({cmp_l, cmp_e, cmp_g});

  // Next-state, operand capture, slice walk and result update.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    l_d     = l;
    e_d     = e;
    g_d     = g;
    err_d   = err;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = word_t'(a);
          b_d     = word_t'(b);
          idx_d   = LAST_IDX;
          state_d = RUN;
        end
      end

      RUN: begin
        if (!cmp_onehot) begin
          // Comparator answer is unusable: report an error, no ordering.
          {l_d, e_d, g_d} = 3'b000;
          err_d           = 1'b1;
          done_d          = 1'b1;
          state_d         = IDLE;
        end else if (cmp_e) begin
          if (idx_q == '0) begin
            {l_d, e_d, g_d} = 3'b010;
            err_d           = 1'b0;
            done_d          = 1'b1;
            state_d         = IDLE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end else begin
          // First unequal slice from the top decides the whole word.
          {l_d, e_d, g_d} = cmp_l ? 3'b100 : 3'b001;
          err_d           = 1'b0;
          done_d          = 1'b1;
          state_d         = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, operand, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are reset too, so the slice outputs come up
    // as 00 rather than undefined after reset.
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      done    <= 1'b0;
      l       <= 1'b0;
      e       <= 1'b0;
      g       <= 1'b0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the same pre-edge values, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      done    <= done_d;
      l       <= l_d;
      e       <= e_d;
      g       <= g_d;
      err     <= err_d;
    end
  end

endmodule
